// File: rtl/char_sprite_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pkg
// Purpose  : Shared constants and types for the character sprite read path.
//            Holds the sprite geometry, the ROM address width, the blink
//            timing defaults, the flash FSM state enum and the raster
//            coordinate type.
// Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    // Character sprite geometry. CHAR_SPRITE_W is also the ROM row stride.
    localparam int CHAR_SPRITE_W     = 41;
    localparam int CHAR_SPRITE_H     = 65;
    // Last address is 41*65-1 = 2664, which needs 12 bits.
    localparam int CHAR_ADDR_W       = 12;

    // Blink sequence defaults.
    localparam int CHAR_FLASH_FRAMES = 32;
    localparam int CHAR_BLINK_LOG2   = 2;

    // Flash FSM states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_t;

    // VGA raster coordinate.
    typedef logic [9:0] coord_t;

    // Frame counter width. Always at least one bit, even when the blink
    // lasts only a single frame.
    function automatic int cnt_width(input int frames);
        return (frames > 1) ? $clog2(frames) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/char_sprite_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : char_sprite_fetch_if
// Purpose  : Read bus between the sprite fetch logic and the sprite ROM.
//            The fetch side presents an address and a valid flag. The ROM
//            returns the pixel colour and its non-transparent flag
//            combinationally for that address.
// Ports    : Player_address - ROM address (fetch -> ROM)
//            addr_valid     - raster inside the sprite box (fetch -> ROM)
//            pixel_on_in    - ROM non-transparent flag (ROM -> fetch)
//            pixel_in       - ROM RGB value (ROM -> fetch)
// Revision : 1.0 - initial release
// ============================================================================
interface char_sprite_fetch_if
    import sprite_pkg::*;
#(
    parameter int ADDR_W = CHAR_ADDR_W
);

    logic [ADDR_W-1:0] Player_address;
    logic              addr_valid;
    logic              pixel_on_in;
    logic [23:0]       pixel_in;

    // Fetch side: drives the address and samples the ROM data.
    modport master (
        output Player_address,
        output addr_valid,
        input  pixel_on_in,
        input  pixel_in
    );

    // ROM side: samples the address and returns the data.
    modport slave (
        input  Player_address,
        input  addr_valid,
        output pixel_on_in,
        output pixel_in
    );

endinterface
`default_nettype wire

// File: rtl/char_sprite_fetch_flash_fsm.sv
`default_nettype none
// ============================================================================
// Module   : sprite_flash_fsm
// Purpose  : Hit-flash (invulnerability blink) controller. A hit starts a
//            blink lasting FLASH_FRAMES frames. The sprite is visible for
//            2**BLINK_LOG2 frames, then hidden for the same number, and so
//            on. A hit during a blink restarts it.
// Ports    : Clk         - system clock
//            Reset_n     - asynchronous active-low reset
//            frame_start - one-cycle pulse at start of vertical blank
//            hit         - one-cycle pulse, character struck
//            visible     - sprite may be drawn this frame
//            flashing    - blink sequence active (registered)
// Revision : 1.0 - initial release
// ============================================================================
module sprite_flash_fsm
    import sprite_pkg::*;
#(
    parameter int FLASH_FRAMES = CHAR_FLASH_FRAMES,
    parameter int BLINK_LOG2   = CHAR_BLINK_LOG2
) (
    input  wire logic Clk,
    input  wire logic Reset_n,
    input  wire logic frame_start,
    input  wire logic hit,
    output logic      visible,
    output logic      flashing
);

    localparam int         CNT_W    = cnt_width(FLASH_FRAMES);
    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_FLASH = FLASH;
    localparam logic [CNT_W-1:0] c_LAST_FRAME = CNT_W'(FLASH_FRAMES - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_flashing;

    // A hit takes priority over frame_start. A hit in the same cycle as
    // frame_start therefore restarts the blink instead of advancing it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (hit) begin
            w_state_nxt = ST_FLASH;
            w_cnt_nxt   = '0;
        end else if ((r_state == ST_FLASH) && frame_start) begin
            if (r_cnt == c_LAST_FRAME) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_flashing <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_flashing <= (w_state_nxt == ST_FLASH);
        end
    end

    // The blink starts with a visible phase because cnt starts at 0.
    assign visible  = (r_state == ST_IDLE) || (r_cnt[BLINK_LOG2] == 1'b0);
    assign flashing = r_flashing;

endmodule
`default_nettype wire

// File: rtl/char_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : char_sprite_fetch
// Purpose  : Read-side driver of the character sprite ROM. Converts the VGA
//            raster coordinate into a sprite ROM address (stage 1). Turns
//            the ROM's combinational pixel and transparency flag into a
//            registered draw output (stage 2). Latches the character
//            position at frame start so the sprite never tears, and hosts
//            the hit-flash controller.
// Ports    : Clk, Reset_n      - clock, asynchronous active-low reset
//            pixel_ce          - pixel clock enable for the pipeline
//            frame_start       - start of vertical blank pulse
//            DrawX, DrawY      - current raster position
//            PosX_in, PosY_in  - live sprite top-left position
//            facing_left_in    - live horizontal mirror flag
//            hit               - character struck pulse
//            rom               - sprite ROM read bus (master side)
//            draw_on           - draw the sprite pixel this slot
//            draw_pixel        - RGB to draw, aligned with draw_on
//            flashing          - blink sequence active
// Revision : 1.0 - initial release
// ============================================================================
module char_sprite_fetch
    import sprite_pkg::*;
#(
    parameter int SPRITE_W     = CHAR_SPRITE_W,
    parameter int SPRITE_H     = CHAR_SPRITE_H,
    parameter int ADDR_W       = CHAR_ADDR_W,
    parameter int FLASH_FRAMES = CHAR_FLASH_FRAMES,
    parameter int BLINK_LOG2   = CHAR_BLINK_LOG2
) (
    input  wire logic          Clk,
    input  wire logic          Reset_n,
    input  wire logic          pixel_ce,
    input  wire logic          frame_start,
    input  wire coord_t        DrawX,
    input  wire coord_t        DrawY,
    input  wire coord_t        PosX_in,
    input  wire coord_t        PosY_in,
    input  wire logic          facing_left_in,
    input  wire logic          hit,
    char_sprite_fetch_if.master rom,
    output logic               draw_on,
    output logic [23:0]        draw_pixel,
    output logic               flashing
);

    // Position and facing, frozen for the whole frame.
    coord_t            r_pos_x;
    coord_t            r_pos_y;
    logic              r_facing;

    // Stage 1: address generation.
    logic [10:0]       w_rel_x;
    logic [10:0]       w_rel_y;
    logic [10:0]       w_col;
    logic              w_inside;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;

    // Stage 2: draw decision.
    logic              r_draw_on;
    logic [23:0]       r_draw_px;
    logic              w_draw;

    logic              w_visible;

    // ------------------------------------------------------------------
    // Position latch. Independent of pixel_ce so that a frame_start
    // pulse is never missed.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pos_x  <= '0;
            r_pos_y  <= '0;
            r_facing <= 1'b0;
        end else if (frame_start) begin
            r_pos_x  <= PosX_in;
            r_pos_y  <= PosY_in;
            r_facing <= facing_left_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 combinational address. The subtraction is one bit wider
    // than the coordinates so that a raster left of or above the sprite
    // yields a negative value. The explicit >= tests reject that case, so
    // the < bounds below only ever see non-negative values. Each row is
    // bounded on its own, so a sprite hanging off the right edge never
    // wraps into the next row.
    // ------------------------------------------------------------------
    assign w_rel_x  = {1'b0, DrawX} - {1'b0, r_pos_x};
    assign w_rel_y  = {1'b0, DrawY} - {1'b0, r_pos_y};
    assign w_inside = (DrawX >= r_pos_x) && (w_rel_x < 11'(SPRITE_W)) &&
                      (DrawY >= r_pos_y) && (w_rel_y < 11'(SPRITE_H));
    assign w_col    = r_facing ? (11'(SPRITE_W - 1) - w_rel_x) : w_rel_x;
    // Row-major address, computed modulo 2**ADDR_W.
    assign w_addr   = ADDR_W'(w_rel_y) * ADDR_W'(SPRITE_W) + ADDR_W'(w_col);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_addr  <= '0;
            r_valid <= 1'b0;
        end else if (pixel_ce) begin
            r_addr  <= w_inside ? w_addr : '0;
            r_valid <= w_inside;
        end
    end

    assign rom.Player_address = r_addr;
    assign rom.addr_valid     = r_valid;

    // ------------------------------------------------------------------
    // Stage 2. The ROM answers combinationally for r_addr, so its data
    // is already aligned with r_valid here.
    // ------------------------------------------------------------------
    assign w_draw = r_valid && rom.pixel_on_in && w_visible;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_draw_on <= 1'b0;
            r_draw_px <= '0;
        end else if (pixel_ce) begin
            r_draw_on <= w_draw;
            r_draw_px <= w_draw ? rom.pixel_in : 24'h000000;
        end
    end

    assign draw_on    = r_draw_on;
    assign draw_pixel = r_draw_px;

    // ------------------------------------------------------------------
    // Hit-flash controller.
    // ------------------------------------------------------------------
    sprite_flash_fsm #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .BLINK_LOG2   (BLINK_LOG2)
    ) u_flash_fsm (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .hit         (hit),
        .visible     (w_visible),
        .flashing    (flashing)
    );

endmodule
`default_nettype wire

// File: tb/tb_char_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_sprite_fetch
// Purpose  : Self-checking bench for char_sprite_fetch. A frame-level
//            reference model predicts the pipeline and blink behaviour
//            from the sprite geometry with plain integer arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_char_sprite_fetch;

    localparam int SW     = 41;
    localparam int SH     = 65;
    localparam int FRAMES = 32;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pixel_ce;
    logic        frame_start;
    logic [9:0]  DrawX, DrawY, PosX_in, PosY_in;
    logic        facing_left_in;
    logic        hit;
    logic        draw_on;
    logic [23:0] draw_pixel;
    logic        flashing;

    char_sprite_fetch_if rom_if ();

    char_sprite_fetch dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .pixel_ce       (pixel_ce),
        .frame_start    (frame_start),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .PosX_in        (PosX_in),
        .PosY_in        (PosY_in),
        .facing_left_in (facing_left_in),
        .hit            (hit),
        .rom            (rom_if.master),
        .draw_on        (draw_on),
        .draw_pixel     (draw_pixel),
        .flashing       (flashing)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          m_px, m_py;
    bit          m_face;
    bit          m_valid;
    int          m_addr;
    bit          m_draw_on;
    logic [23:0] m_draw_px;
    bit          m_flash;
    int          m_frames;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_px = 0; m_py = 0; m_face = 0;
        m_valid = 0; m_addr = 0;
        m_draw_on = 0; m_draw_px = '0;
        m_flash = 0; m_frames = 0;
    endtask

    // Predict the effect of one clock edge from the inputs held across it.
    task automatic model_edge();
        bit vis;
        int rx, ry, col;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        vis = !m_flash || (((m_frames / 4) % 2) == 0);
        if (pixel_ce) begin
            m_draw_on = m_valid && rom_if.pixel_on_in && vis;
            m_draw_px = m_draw_on ? rom_if.pixel_in : 24'h0;
            rx = int'(DrawX) - m_px;
            ry = int'(DrawY) - m_py;
            if (rx >= 0 && rx < SW && ry >= 0 && ry < SH) begin
                col     = m_face ? (SW - 1 - rx) : rx;
                m_valid = 1;
                m_addr  = (ry * SW + col) % 4096;
            end else begin
                m_valid = 0;
                m_addr  = 0;
            end
        end
        if (frame_start) begin
            m_px = int'(PosX_in); m_py = int'(PosY_in); m_face = facing_left_in;
        end
        if (hit) begin
            m_flash = 1; m_frames = 0;
        end else if (m_flash && frame_start) begin
            m_frames++;
            if (m_frames >= FRAMES) begin
                m_flash = 0; m_frames = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("addr",       32'(rom_if.Player_address), 32'(m_addr));
        chk("addr_valid", 32'(rom_if.addr_valid),     32'(m_valid));
        chk("draw_on",    32'(draw_on),               32'(m_draw_on));
        chk("draw_pixel", 32'(draw_pixel),            32'(m_draw_px));
        chk("flashing",   32'(flashing),              32'(m_flash));
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic raster(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
    endtask

    logic [11:0] snap_addr;
    logic        snap_don;
    logic [23:0] snap_px;
    bit          restarted;

    initial begin
        // ---------------- Reset with random inputs ----------------
        Reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            pixel_ce           = 1'($urandom);
            frame_start        = 1'($urandom);
            hit                = 1'($urandom);
            DrawX              = 10'($urandom);
            DrawY              = 10'($urandom);
            PosX_in            = 10'($urandom);
            PosY_in            = 10'($urandom);
            facing_left_in     = 1'($urandom);
            rom_if.pixel_on_in = 1'($urandom);
            rom_if.pixel_in    = 24'($urandom);
            tick();
        end
        chk("reset_addr", 32'(rom_if.Player_address), 32'd0);
        chk("reset_flashing", 32'(flashing), 32'd0);

        pixel_ce = 1'b1; frame_start = 1'b0; hit = 1'b0;
        rom_if.pixel_on_in = 1'b0; rom_if.pixel_in = 24'h0;
        DrawX = 10'd0; DrawY = 10'd0;
        @(negedge Clk);
        Reset_n = 1'b1;

        // ---------------- Latch position (100,50) ----------------
        PosX_in = 10'd100; PosY_in = 10'd50; facing_left_in = 1'b0;
        pulse_frame();

        // ---------------- Address, no mirror ----------------
        raster(105, 52);
        chk("addr_87", 32'(rom_if.Player_address), 32'd87);
        chk("valid_87", 32'(rom_if.addr_valid), 32'd1);
        rom_if.pixel_on_in = 1'b1; rom_if.pixel_in = 24'hfba500;
        tick();
        chk("draw_on_first", 32'(draw_on), 32'd1);
        chk("draw_pixel_first", 32'(draw_pixel), 32'hfba500);

        // ---------------- Mirror ----------------
        facing_left_in = 1'b1;
        pulse_frame();
        tick();
        chk("addr_mirror_117", 32'(rom_if.Player_address), 32'd117);
        facing_left_in = 1'b0;
        pulse_frame();

        // ---------------- Bounds ----------------
        raster(141, 52);
        chk("right_edge_valid", 32'(rom_if.addr_valid), 32'd0);
        chk("right_edge_addr", 32'(rom_if.Player_address), 32'd0);
        raster(140, 114);
        chk("last_addr_2664", 32'(rom_if.Player_address), 32'd2664);
        raster(99, 52);
        chk("left_of_sprite", 32'(rom_if.addr_valid), 32'd0);
        raster(105, 115);
        chk("below_sprite", 32'(rom_if.addr_valid), 32'd0);

        // ---------------- Transparency ----------------
        rom_if.pixel_on_in = 1'b0;
        raster(105, 52);
        tick();
        chk("transparent_draw_on", 32'(draw_on), 32'd0);
        chk("transparent_pixel", 32'(draw_pixel), 32'd0);

        // ---------------- pixel_ce hold ----------------
        rom_if.pixel_on_in = 1'b1;
        tick();
        snap_addr = rom_if.Player_address;
        snap_don  = draw_on;
        snap_px   = draw_pixel;
        pixel_ce  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            DrawX = 10'($urandom); DrawY = 10'($urandom);
            rom_if.pixel_on_in = 1'($urandom);
            rom_if.pixel_in    = 24'($urandom);
            tick();
        end
        chk("hold_addr", 32'(rom_if.Player_address), 32'(snap_addr));
        chk("hold_draw_on", 32'(draw_on), 32'(snap_don));
        chk("hold_pixel", 32'(draw_pixel), 32'(snap_px));
        pixel_ce = 1'b1;

        // ---------------- Position latch ----------------
        PosX_in = 10'd200;
        tick();
        raster(105, 52);
        chk("latch_old_pos", 32'(rom_if.Player_address), 32'd87);
        pulse_frame();
        raster(205, 52);
        chk("latch_new_pos", 32'(rom_if.Player_address), 32'd87);

        // ---------------- Randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            pixel_ce           = ($urandom_range(0, 3) != 0);
            frame_start        = ($urandom_range(0, 19) == 0);
            hit                = ($urandom_range(0, 99) == 0);
            facing_left_in     = 1'($urandom);
            rom_if.pixel_on_in = 1'($urandom);
            rom_if.pixel_in    = 24'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                PosX_in = 10'($urandom_range(0, 1023));
                PosY_in = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 7) == 0) begin
                DrawX = 10'($urandom);
                DrawY = 10'($urandom);
            end else begin
                DrawX = 10'(m_px + int'($urandom_range(0, 50)) - 5);
                DrawY = 10'(m_py + int'($urandom_range(0, 75)) - 5);
            end
            tick();
        end
        frame_start = 1'b0; hit = 1'b0; pixel_ce = 1'b1;

        // Let any running blink finish so the directed flash starts clean.
        for (int i = 0; i < 40; i++) pulse_frame();
        chk("idle_before_hit", 32'(flashing), 32'd0);

        // ---------------- Flash sequence ----------------
        PosX_in = 10'd100; PosY_in = 10'd50; facing_left_in = 1'b0;
        pulse_frame();
        DrawX = 10'd110; DrawY = 10'd60;
        rom_if.pixel_on_in = 1'b1; rom_if.pixel_in = 24'h12ab34;
        hit = 1'b1;
        tick();
        hit = 1'b0;
        chk("flashing_after_hit", 32'(flashing), 32'd1);
        restarted = 0;
        for (int f = 0; f < 60; f++) begin
            if (!restarted && m_flash && m_frames == 20) begin
                hit = 1'b1;
                restarted = 1;
            end
            pulse_frame();
            hit = 1'b0;
            for (int k = 0; k < 3; k++) tick();
        end
        chk("restart_seen", 32'(restarted), 32'd1);
        chk("flash_done", 32'(flashing), 32'd0);
        chk("visible_after_flash", 32'(draw_on), 32'd1);

        // ---------------- Asynchronous reset mid-frame ----------------
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        @(negedge Clk);
        Reset_n = 1'b1;
        raster(105, 52);
        chk("pos_cleared_by_reset", 32'(rom_if.addr_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
